// File: rtl/face_result_writer.sv
// face_result_writer
// Avalon-MM write master feeding the 4-word result mailbox. Each accepted
// detection result is written as: invalidate word3, words 0..2, commit word3.
// Software therefore never sees a valid word3 over a half-written record.
// Optional readback verification: define FACE_RESULT_WRITER_VERIFY_EN.
module face_result_writer #(
    parameter int COORD_W = 16,
    parameter int SEQ_W   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               freeze,
    input  logic               det_valid,
    output logic               det_ready,
    input  logic [COORD_W-1:0] det_x,
    input  logic [COORD_W-1:0] det_y,
    input  logic [COORD_W-1:0] det_w,
    input  logic [COORD_W-1:0] det_h,
    input  logic [COORD_W-1:0] det_score,
    input  logic [COORD_W-1:0] det_frame,
    output logic [1:0]         avm_address,
    output logic [3:0]         avm_byteenable,
    output logic               avm_chipselect,
    output logic               avm_write,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    output logic               avm_clken,
    output logic               done,
    output logic               verify_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_INVAL, S_W0, S_W1, S_W2, S_COMMIT,
        S_RD0, S_RD1, S_RD2, S_RD3, S_RDCHK
    } state_t;

    state_t           state, next_state;
    logic [15:0]      cap_x, cap_y, cap_w, cap_h, cap_score, cap_frame;
    logic [SEQ_W-1:0] seq;
    logic             done_pend;
    logic             finish;
    logic             acc_wr, acc_rd;
    logic [1:0]       acc_addr;
    logic [31:0]      acc_wdata;

    // Mailbox image of the captured record; word3 is the commit word for s.
    function automatic logic [31:0] pack_word(input logic [1:0] addr,
                                              input logic [SEQ_W-1:0] s);
        case (addr)
            2'd0:    pack_word = {cap_y, cap_x};
            2'd1:    pack_word = {cap_h, cap_w};
            2'd2:    pack_word = {cap_frame, cap_score};
            default: pack_word = {1'b1, 15'(s), 16'h0000};
        endcase
    endfunction

    assign det_ready      = (state == S_IDLE) && !freeze && !reset;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = ~freeze;
    assign avm_address    = acc_addr;
    assign avm_writedata  = acc_wdata;
    assign avm_chipselect = (acc_wr || acc_rd) && !freeze;
    assign avm_write      = acc_wr && !freeze;
    assign done           = done_pend && !freeze;

`ifdef FACE_RESULT_WRITER_VERIFY_EN
    assign finish = (state == S_RDCHK) && !freeze;
`else
    assign finish = (state == S_COMMIT) && !freeze;
`endif

    // Next-state and access decode; freeze holds the current state.
    always_comb begin
        // NOTE: every signal of this block gets a default first, so no path can infer a latch.
        next_state = state;
        acc_wr     = 1'b0;
        acc_rd     = 1'b0;
        acc_addr   = 2'd0;
        acc_wdata  = 32'h0;
        case (state)
            S_IDLE: if (det_valid && det_ready) next_state = S_INVAL;
            S_INVAL: begin
                acc_wr     = 1'b1;
                acc_addr   = 2'd3;
                next_state = S_W0;
            end
            S_W0: begin
                acc_wr     = 1'b1;
                acc_addr   = 2'd0;
                acc_wdata  = pack_word(2'd0, seq);
                next_state = S_W1;
            end
            S_W1: begin
                acc_wr     = 1'b1;
                acc_addr   = 2'd1;
                acc_wdata  = pack_word(2'd1, seq);
                next_state = S_W2;
            end
            S_W2: begin
                acc_wr     = 1'b1;
                acc_addr   = 2'd2;
                acc_wdata  = pack_word(2'd2, seq);
                next_state = S_COMMIT;
            end
            S_COMMIT: begin
                acc_wr     = 1'b1;
                acc_addr   = 2'd3;
                acc_wdata  = pack_word(2'd3, seq);
`ifdef FACE_RESULT_WRITER_VERIFY_EN
                next_state = S_RD0;
`else
                next_state = S_IDLE;
`endif
            end
`ifdef FACE_RESULT_WRITER_VERIFY_EN
            S_RD0: begin
                acc_rd     = 1'b1;
                acc_addr   = 2'd0;
                next_state = S_RD1;
            end
            S_RD1: begin
                acc_rd     = 1'b1;
                acc_addr   = 2'd1;
                next_state = S_RD2;
            end
            S_RD2: begin
                acc_rd     = 1'b1;
                acc_addr   = 2'd2;
                next_state = S_RD3;
            end
            S_RD3: begin
                acc_rd     = 1'b1;
                acc_addr   = 2'd3;
                next_state = S_RDCHK;
            end
            S_RDCHK: next_state = S_IDLE;
`endif
            default: next_state = S_IDLE;
        endcase
        if (freeze) next_state = state;
    end

    // State register, commit sequence counter and deferred done pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            seq       <= '0;
            done_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_COMMIT && !freeze) seq <= seq + 1'b1;
            done_pend <= finish || (done_pend && freeze);
        end
    end

    // Result capture on an accepted handshake, zero-extended to 16 bits.
    always_ff @(posedge clk) begin
        // NOTE: the captured record is not reset; it is only read after a capture.
        if (det_valid && det_ready) begin
            cap_x     <= 16'(det_x);
            cap_y     <= 16'(det_y);
            cap_w     <= 16'(det_w);
            cap_h     <= 16'(det_h);
            cap_score <= 16'(det_score);
            cap_frame <= 16'(det_frame);
        end
    end

`ifdef FACE_RESULT_WRITER_VERIFY_EN
    logic       cmp_pend;
    logic [1:0] cmp_addr;
    logic       verr;

    // Readback compare one cycle behind each unfrozen read; seq has already
    // advanced past the committed value, so word3 is checked against seq-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_pend <= 1'b0;
            cmp_addr <= 2'd0;
            verr     <= 1'b0;
        end else begin
            cmp_pend <= acc_rd && !freeze;
            cmp_addr <= acc_addr;
            if (cmp_pend && (avm_readdata != pack_word(cmp_addr, SEQ_W'(seq - 1'b1))))
                verr <= 1'b1;
        end
    end
    assign verify_err = verr;
`else
    logic unused_rdata;
    assign unused_rdata = ^avm_readdata;
    assign verify_err   = 1'b0;
`endif

endmodule

// File: tb/tb_face_result_writer.sv
// Testbench for face_result_writer: directed scenarios plus random results,
// checked against a transaction-level model of the mailbox write sequence.
`timescale 1ns/1ps
module tb_face_result_writer;

`ifdef FACE_RESULT_WRITER_VERIFY_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 6;
`endif

    typedef struct packed {
        logic [15:0] x, y, w, h, s, f;
    } det_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic        det_valid = 1'b0;
    logic        det_ready;
    logic [15:0] det_x = '0, det_y = '0, det_w = '0, det_h = '0;
    logic [15:0] det_score = '0, det_frame = '0;
    logic [1:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect, avm_write, avm_clken, done, verify_err;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;

    face_result_writer dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .det_valid(det_valid), .det_ready(det_ready),
        .det_x(det_x), .det_y(det_y), .det_w(det_w), .det_h(det_h),
        .det_score(det_score), .det_frame(det_frame),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_clken(avm_clken), .done(done), .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mailbox RAM model: registered read, gated by the clock enable.
    logic [31:0] mem [4] = '{default: 32'h0};
    bit          corrupt = 1'b0;
    always @(posedge clk) begin
        if (avm_clken && avm_chipselect) begin
            if (avm_write) mem[avm_address] <= avm_writedata;
            else avm_readdata <= mem[avm_address] ^
                                 ((corrupt && avm_address == 2'd1) ? 32'h0000_0100 : 32'h0);
        end
    end

    // Bus monitor: logs writes and done pulses, counts freeze-rule breaches.
    wr_t wr_q[$];
    int  done_q[$];
    int  frz_viol = 0;
    always @(negedge clk) begin
        #2;
        if (avm_chipselect && avm_write) wr_q.push_back('{avm_address, avm_writedata, cyc});
        if (done) done_q.push_back(cyc);
        if (freeze && (avm_chipselect || avm_write || avm_clken || det_ready || done)) frz_viol++;
        if (!freeze && !avm_clken) frz_viol++;
    end

    int errors = 0;
    int checks = 0;
    int seq_m  = 0;
    int wr_idx = 0;
    int done_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: k-th write of a record (0 = invalidate, 4 = commit).
    function automatic logic [31:0] model_word(input det_t d, input int k, input int s);
        case (k)
            0:       return 32'h0;
            1:       return {d.y, d.x};
            2:       return {d.h, d.w};
            3:       return {d.f, d.s};
            default: return 32'h8000_0000 | (32'(s) << 16);
        endcase
    endfunction

    function automatic logic [1:0] model_addr(input int k);
        return (k == 0 || k == 4) ? 2'd3 : 2'(k - 1);
    endfunction

    function automatic det_t rand_det();
        det_t d;
        d.x = 16'($urandom); d.y = 16'($urandom); d.w = 16'($urandom);
        d.h = 16'($urandom); d.s = 16'($urandom); d.f = 16'($urandom);
        return d;
    endfunction

    task automatic run_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Present a result at a negedge; returns the cycle whose closing edge accepts it.
    task automatic offer(input det_t d, output int h);
        det_x = d.x; det_y = d.y; det_w = d.w; det_h = d.h;
        det_score = d.s; det_frame = d.f;
        det_valid = 1'b1;
        h = -1;
        for (int i = 0; i < 40 && h < 0; i++) begin
            #1;
            if (det_ready) h = cyc;
            else @(negedge clk);
        end
        check("handshake_seen", 32'(h >= 0), 32'd1);
    endtask

    // Compare one record's writes and done pulse with the model; a freeze of
    // fl cycles starting at offset fo delays every event at or after fo.
    task automatic expect_txn(input string tag, input det_t d, input int h,
                              input int fo, input int fl);
        wr_t w;
        int  off;
        for (int i = 0; i < 60 && (done_q.size() <= done_idx || wr_q.size() < wr_idx + 5); i++)
            @(negedge clk);
        #3;
        check({tag, "_done_seen"}, 32'(done_q.size() > done_idx), 32'd1);
        if (done_q.size() > done_idx) begin
            check({tag, "_done_cyc"}, 32'(done_q[done_idx] - h), 32'(LAT + ((fo > 0) ? fl : 0)));
            done_idx++;
        end
        for (int k = 0; k < 5; k++) begin
            if (wr_q.size() > wr_idx) begin
                w = wr_q[wr_idx];
                wr_idx++;
                off = k + 1 + ((fo > 0 && k + 1 >= fo) ? fl : 0);
                check({tag, "_addr"}, 32'(w.addr), 32'(model_addr(k)));
                check({tag, "_data"}, w.data, model_word(d, k, seq_m));
                check({tag, "_wcyc"}, 32'(w.cyc - h), 32'(off));
            end else begin
                check({tag, "_write_seen"}, 32'd0, 32'd1);
            end
        end
        seq_m = (seq_m + 1) % 32768;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        det_t d;
        det_t bb [3];
        int   h;
        int   hb [3];

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", det_ready, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_done", done, 0);
        check("rst_verr", verify_err, 0);
        check("byteenable", avm_byteenable, 32'hF);
        reset = 1'b0;
        @(negedge clk); #1;
        check("idle_ready", det_ready, 1);
        check("idle_clken", avm_clken, 1);

        // Directed record from the bring-up example.
        d = '{x: 16'h0010, y: 16'h0020, w: 16'h0030, h: 16'h0040, s: 16'h7F00, f: 16'h0005};
        @(negedge clk);
        offer(d, h);
        @(negedge clk); det_valid = 1'b0;
        expect_txn("directed", d, h, 0, 0);
        check("directed_no_extra", 32'(wr_q.size() - wr_idx), 0);

        // Three back-to-back results with det_valid held high.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bb[i] = rand_det();
            offer(bb[i], hb[i]);
            @(negedge clk);
        end
        det_valid = 1'b0;
        check("b2b_gap01", 32'(hb[1] - hb[0]), 32'(LAT));
        check("b2b_gap12", 32'(hb[2] - hb[1]), 32'(LAT));
        for (int i = 0; i < 3; i++) expect_txn("b2b", bb[i], hb[i], 0, 0);

        // Freeze for 3 cycles during W1.
        d = rand_det();
        @(negedge clk);
        offer(d, h);
        @(negedge clk); det_valid = 1'b0;
        run_to(h + 3); freeze = 1'b1; #1;
        check("frz_cs", avm_chipselect, 0);
        check("frz_clken", avm_clken, 0);
        run_to(h + 6); freeze = 1'b0; #1;
        check("frz_reissue_addr", avm_address, 1);
        check("frz_reissue_cs", avm_chipselect, 1);
        expect_txn("freeze_w1", d, h, 3, 3);
        check("freeze_no_extra", 32'(wr_q.size() - wr_idx), 0);

        // Reset during W0.
        d = rand_det();
        @(negedge clk);
        offer(d, h);
        @(negedge clk); det_valid = 1'b0;
        run_to(h + 2); #1;
        check("w0_addr", avm_address, 0);
        reset = 1'b1; #1;
        check("rst_mid_ready", det_ready, 0);
        run_to(h + 3); reset = 1'b0; #1;
        check("rst_mid_cs", avm_chipselect, 0);
        check("rst_mid_write", avm_write, 0);
        check("rst_mid_addr", avm_address, 0);
        check("rst_mid_wdata", avm_writedata, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_verr", verify_err, 0);
        check("rst_mid_ready1", det_ready, 1);
        check("mbox_word3_invalid", mem[3][31], 0);
        wr_idx = wr_q.size();
        done_idx = done_q.size();
        seq_m = 0;
        d = rand_det();
        @(negedge clk);
        offer(d, h);
        @(negedge clk); det_valid = 1'b0;
        expect_txn("after_reset", d, h, 0, 0);

        // Sequence counter wrap from its maximum.
        @(negedge clk);
        force dut.seq = 15'h7FFF;
        @(negedge clk);
        release dut.seq;
        seq_m = 32'h7FFF;
        for (int i = 0; i < 2; i++) begin
            d = rand_det();
            @(negedge clk);
            offer(d, h);
            @(negedge clk); det_valid = 1'b0;
            expect_txn("seq_wrap", d, h, 0, 0);
        end

        // Random results with random freeze windows.
        for (int i = 0; i < 8; i++) begin
            int fo, fl;
            d  = rand_det();
            fo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, LAT));
            fl = int'($urandom_range(1, 3));
            @(negedge clk);
            offer(d, h);
            @(negedge clk); det_valid = 1'b0;
            if (fo > 0) begin
                run_to(h + fo); freeze = 1'b1;
                run_to(h + fo + fl); freeze = 1'b0;
            end
            expect_txn("rand", d, h, fo, fl);
            check("rand_no_extra", 32'(wr_q.size() - wr_idx), 0);
        end
        check("verify_err_clean", verify_err, 0);

`ifdef FACE_RESULT_WRITER_VERIFY_EN
        // Corrupted readback of word1.
        corrupt = 1'b1;
        d = rand_det();
        @(negedge clk);
        offer(d, h);
        @(negedge clk); det_valid = 1'b0;
        run_to(h + 8); #1;
        check("verr_before", verify_err, 0);
        run_to(h + 9); #1;
        check("verr_set", verify_err, 1);
        expect_txn("corrupt", d, h, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("verr_sticky", verify_err, 1);
        corrupt = 1'b0;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        check("verr_cleared", verify_err, 0);
        wr_idx = wr_q.size();
        done_idx = done_q.size();
        seq_m = 0;
`endif

        check("freeze_rules", 32'(frz_viol), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
